fixed_mac_source: RTL and testbench

Transmitter side of the fixed-point multiply-accumulate stream interface. It buffers operand pairs loaded by a host into an internal FIFO. On start it drives the A and B operand channels (data/valid/ready/last) for a vector of vec_len elements, then captures the single accumulated result returned by the MAC's out channel and holds it for the host. It sits between the host/control logic and the fixed-point MAC block.

---
 rtl/fixed_mac_source.sv | 163 ++++++++++++++++
 tb/tb_fixed_mac_source.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_source.sv
// Buffers host operand pairs and streams them as lockstep A/B vectors to a fixed-point MAC; start->A_valid 1 cycle, result captured 1 cycle after res_valid.
// Backpressure: ld_ready low while FIFO full, A/B stall on A_ready&B_ready; define FIXED_MAC_SOURCE_TIMEOUT_EN to bound the result wait.
module fixed_mac_source #(
  parameter int WI1     = 4,
  parameter int WF1     = 8,
  parameter int WI2     = 3,
  parameter int WF2     = 5,
  parameter int WIO     = 15,
  parameter int WFO     = 30,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WI1+WF1-1:0]   ld_A_data,
  input  logic [WI2+WF2-1:0]   ld_B_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 start,
  input  logic [LEN_W-1:0]     vec_len,
  output logic                 busy,
  output logic [WI1+WF1-1:0]   A_data,
  output logic                 A_valid,
  input  logic                 A_ready,
  output logic                 A_last,
  output logic [WI2+WF2-1:0]   B_data,
  output logic                 B_valid,
  input  logic                 B_ready,
  output logic                 B_last,
  input  logic [WIO+WFO-1:0]   res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic [WIO+WFO-1:0]   result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 err_timeout
);
  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  if (2**LEN_W <= DEPTH || TIMEOUT < 1) begin : g_cfg_check
    $error("fixed_mac_source: requires 2^LEN_W > DEPTH and TIMEOUT >= 1");
  end

  logic [1:0]       state;
  logic [WA-1:0]    mem_a [DEPTH];
  logic [WB-1:0]    mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [LEN_W-1:0] len_r, idx, last_idx;
  logic             push, pop, fifo_empty, xfer, timeout_hit;

  assign fifo_empty = (count == '0);
  assign ld_ready   = (count != CW'(DEPTH));
  assign push       = ld_valid & ld_ready;

  // Valid depends only on state and occupancy, never on the ready inputs.
  assign A_valid  = (state == S_SEND) & ~fifo_empty;
  assign B_valid  = A_valid;
  assign xfer     = A_valid & A_ready & B_ready;
  assign pop      = xfer;
  assign last_idx = len_r - LEN_W'(1);
  assign A_last   = A_valid & (idx == last_idx);
  assign B_last   = A_last;
  assign A_data   = A_valid ? mem_a[rd_ptr] : '0;
  assign B_data   = A_valid ? mem_b[rd_ptr] : '0;

  assign busy         = (state != S_IDLE);
  assign res_ready    = (state == S_WAIT);
  assign result_valid = (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= ld_A_data;
      mem_b[wr_ptr] <= ld_B_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FIXED_MAC_SOURCE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_r;

  assign timeout_hit = (state == S_WAIT) & ~res_valid & (tcnt == TW'(TIMEOUT - 1));
  assign err_timeout = err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt  <= '0;
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_hit;
      if (state != S_WAIT) tcnt <= '0;
      else                 tcnt <= tcnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      len_r  <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && vec_len != '0) begin
            len_r <= vec_len;
            idx   <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            idx <= idx + LEN_W'(1);
            if (A_last) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Only the first res_valid cycle is taken; HOLD drops res_ready.
          if (res_valid) begin
            result <= res_data;
            state  <= S_HOLD;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (result_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_mac_source.sv
// Self-checking bench for fixed_mac_source: scoreboard of loaded pairs checked at each A/B transfer.
module tb_fixed_mac_source;
  localparam int WA = 12;
  localparam int WB = 8;
  localparam int WR = 45;
  localparam int LW = 5;
  localparam int SH = 30 - 8 - 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [WA-1:0] ld_A_data;
  logic [WB-1:0] ld_B_data;
  logic          ld_valid, ld_ready, start, busy;
  logic [LW-1:0] vec_len;
  logic [WA-1:0] A_data;
  logic [WB-1:0] B_data;
  logic          A_valid, A_ready, A_last, B_valid, B_ready, B_last;
  logic [WR-1:0] res_data, result;
  logic          res_valid, res_ready, result_valid, result_ready, err_timeout;

  int checks = 0;
  int passed = 0;
  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];
  longint acc = 0;

  always #5 clk = ~clk;

  fixed_mac_source dut (
    .clk(clk), .reset(reset),
    .ld_A_data(ld_A_data), .ld_B_data(ld_B_data), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .start(start), .vec_len(vec_len), .busy(busy),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready), .A_last(A_last),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready), .B_last(B_last),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [WA-1:0] a, input logic [WB-1:0] b);
    ld_A_data = a;
    ld_B_data = b;
    ld_valid  = 1'b1;
    tick();
    ld_valid  = 1'b0;
    qa.push_back(a);
    qb.push_back(b);
    acc += longint'($signed(a)) * longint'($signed(b));
  endtask

  task automatic start_vec(input int len);
    vec_len = LW'(len);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // mode 0: readies held high; mode 1: readies follow 1,0,0,1 repeating.
  task automatic run_vector(input int base, input int cnt, input int total, input int mode,
                            output int cyc);
    int nx = 0;
    int c = 0;
    bit stalled = 0;
    bit x;
    logic [WA-1:0] pa, ea;
    logic [WB-1:0] pb, eb;
    pa = '0;
    pb = '0;
    while (nx < cnt && c < 200) begin
      A_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      B_ready = A_ready;
      checks++;
      if (A_valid !== B_valid || A_last !== B_last)
        $display("FAIL lockstep: valid %b/%b last %b/%b required equal", A_valid, B_valid, A_last, B_last);
      else passed++;
      if (stalled && A_valid) begin
        checks++;
        if (A_data !== pa || B_data !== pb)
          $display("FAIL stall_hold: got %h/%h required %h/%h", A_data, B_data, pa, pb);
        else passed++;
      end
      x = A_valid & A_ready & B_ready;
      if (x) begin
        checks++;
        if (qa.size() == 0) begin
          $display("FAIL scoreboard_empty: xfer with no expected entry");
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          if (A_data !== ea || B_data !== eb)
            $display("FAIL xfer_data %0d: got %h/%h required %h/%h", base + nx, A_data, B_data, ea, eb);
          else passed++;
        end
        checks++;
        if (A_last !== 1'(base + nx == total - 1))
          $display("FAIL last_flag %0d: got %b required %b", base + nx, A_last, (base + nx == total - 1));
        else passed++;
        nx++;
      end
      stalled = A_valid && !x;
      pa = A_data;
      pb = B_data;
      tick();
      c++;
    end
    A_ready = 1'b0;
    B_ready = 1'b0;
    cyc = c;
    checks++;
    if (nx != cnt) $display("FAIL xfer_count: got %0d required %0d", nx, cnt);
    else passed++;
  endtask

  task automatic finish_result();
    logic [WR-1:0] exp_res;
    exp_res = WR'(acc <<< SH);
    checks++;
    if (res_ready !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL wait_res: res_ready %b result_valid %b required 1/0", res_ready, result_valid);
    else passed++;
    res_data  = exp_res;
    res_valid = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b1 || result !== exp_res || res_ready !== 1'b0)
      $display("FAIL capture: valid %b result %h res_ready %b required 1 %h 0", result_valid, result, res_ready, exp_res);
    else passed++;
    res_data = ~exp_res;
    tick();
    res_valid = 1'b0;
    res_data  = '0;
    checks++;
    if (result_valid !== 1'b1 || result !== exp_res)
      $display("FAIL hold_stable: valid %b result %h required 1 %h", result_valid, result, exp_res);
    else passed++;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== exp_res)
      $display("FAIL release: busy %b valid %b result %h required 0 0 %h", busy, result_valid, result, exp_res);
    else passed++;
    acc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ld_ready, busy, A_valid, B_valid, A_last, B_last, res_ready, result_valid, err_timeout} !== 9'b1_0000_0000)
      $display("FAIL reset_ctrl: got %b required 100000000",
               {ld_ready, busy, A_valid, B_valid, A_last, B_last, res_ready, result_valid, err_timeout});
    else passed++;
    checks++;
    if (A_data !== '0 || B_data !== '0 || result !== '0)
      $display("FAIL reset_data: got %h %h %h required zeros", A_data, B_data, result);
    else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    load_pair(12'h100, 8'h20);
    load_pair(12'h200, 8'h20);
    load_pair(12'h080, 8'h40);
    start_vec(3);
    checks++;
    if (busy !== 1'b1 || A_valid !== 1'b1)
      $display("FAIL start_latency: busy %b A_valid %b required 1/1", busy, A_valid);
    else passed++;
    run_vector(0, 3, 3, 0, cyc);
    checks++;
    if (cyc != 3) $display("FAIL back_to_back: got %0d cycles required 3", cyc);
    else passed++;
    finish_result();
  endtask

  task automatic test_stall();
    int cyc;
    load_pair(12'h100, 8'h20);
    load_pair(12'h200, 8'h20);
    load_pair(12'h080, 8'h40);
    start_vec(3);
    run_vector(0, 3, 3, 1, cyc);
    finish_result();
  endtask

  task automatic test_full();
    int cyc;
    logic [WA-1:0] ea;
    logic [WB-1:0] eb;
    for (int i = 0; i < 16; i++) begin
      load_pair(WA'(12'h010 * i + 1), WB'(i + 1));
      if (i == 14) begin
        checks++;
        if (ld_ready !== 1'b1) $display("FAIL ld_ready_15: got %b required 1", ld_ready);
        else passed++;
      end
    end
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL ld_ready_full: got %b required 0", ld_ready);
    else passed++;
    start_vec(16);
    ld_A_data = 12'h7ff;
    ld_B_data = 8'h7f;
    ld_valid  = 1'b1;
    A_ready   = 1'b1;
    B_ready   = 1'b1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (ld_ready !== 1'b0 || A_valid !== 1'b1 || A_data !== ea || B_data !== eb)
      $display("FAIL full_pop: ld_ready %b valid %b data %h/%h required 0 1 %h/%h", ld_ready, A_valid, A_data, B_data, ea, eb);
    else passed++;
    tick();
    ld_valid = 1'b0;
    A_ready  = 1'b0;
    B_ready  = 1'b0;
    checks++;
    if (ld_ready !== 1'b1) $display("FAIL after_full_pop: ld_ready %b required 1", ld_ready);
    else passed++;
    run_vector(1, 15, 16, 0, cyc);
    finish_result();
    start_vec(1);
    tick();
    checks++;
    if (A_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL rejected_push: A_valid %b busy %b required 0 1", A_valid, busy);
    else passed++;
    load_pair(12'hf00, 8'hc0);
    run_vector(0, 1, 1, 0, cyc);
    finish_result();
  endtask

  task automatic test_partial();
    int cyc;
    load_pair(12'h040, 8'h10);
    load_pair(12'hfc0, 8'h08);
    start_vec(4);
    run_vector(0, 2, 4, 0, cyc);
    tick();
    tick();
    checks++;
    if (A_valid !== 1'b0 || busy !== 1'b1 || res_ready !== 1'b0)
      $display("FAIL underrun: A_valid %b busy %b res_ready %b required 0 1 0", A_valid, busy, res_ready);
    else passed++;
    load_pair(12'h123, 8'h45);
    load_pair(12'h800, 8'h80);
    run_vector(2, 2, 4, 0, cyc);
    finish_result();
  endtask

  task automatic test_zero_len();
    start_vec(0);
    checks++;
    if (busy !== 1'b0 || A_valid !== 1'b0)
      $display("FAIL zero_len: busy %b A_valid %b required 0 0", busy, A_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    load_pair(12'h111, 8'h22);
    load_pair(12'h333, 8'h44);
    load_pair(12'h555, 8'h66);
    start_vec(3);
    run_vector(0, 1, 3, 0, cyc);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ld_ready, busy, A_valid, B_valid, A_last, res_ready, result_valid} !== 7'b100_0000)
      $display("FAIL mid_reset_ctrl: got %b required 1000000",
               {ld_ready, busy, A_valid, B_valid, A_last, res_ready, result_valid});
    else passed++;
    checks++;
    if (A_data !== '0 || result !== '0)
      $display("FAIL mid_reset_data: got %h %h required 0 0", A_data, result);
    else passed++;
    tick();
    reset = 1'b1;
    qa.delete();
    qb.delete();
    acc = 0;
    tick();
    start_vec(1);
    tick();
    checks++;
    if (A_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL fifo_cleared: A_valid %b busy %b required 0 1", A_valid, busy);
    else passed++;
    load_pair(12'h0ff, 8'h01);
    run_vector(0, 1, 1, 0, cyc);
    finish_result();
  endtask

  initial begin
    reset = 1'b0;
    ld_A_data = '0;
    ld_B_data = '0;
    ld_valid = 1'b0;
    start = 1'b0;
    vec_len = '0;
    A_ready = 1'b0;
    B_ready = 1'b0;
    res_data = '0;
    res_valid = 1'b0;
    result_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_partial();
    test_zero_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
